// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: opcodes, ALU function codes,
// sequencer states and instruction classes.
package cu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_ADI  = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_BRZ  = 4'hC;
    localparam logic [3:0] OP_BRN  = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] FS_A   = 4'b0000;
    localparam logic [3:0] FS_ADD = 4'b0010;
    localparam logic [3:0] FS_SUB = 4'b0101;
    localparam logic [3:0] FS_AND = 4'b1000;
    localparam logic [3:0] FS_OR  = 4'b1001;
    localparam logic [3:0] FS_XOR = 4'b1010;
    localparam logic [3:0] FS_NOT = 4'b1011;
    localparam logic [3:0] FS_B   = 4'b1100;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP    = 3'd0,
        CL_ALU    = 3'd1,
        CL_IMM    = 3'd2,
        CL_LD     = 3'd3,
        CL_ST     = 3'd4,
        CL_BRANCH = 3'd5,
        CL_JMP    = 3'd6,
        CL_HALT   = 3'd7
    } iclass_t;

    // Branch offsets are signed 6-bit; PC arithmetic is 8-bit and wraps.
    function automatic logic [7:0] sext6(input logic [5:0] imm);
        return {{2{imm[5]}}, imm};
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Purely combinational opcode decoder: ALU function, operand/write-data
// selects, register-write enable and instruction class.
module cu_decode
    import cu_pkg::*;
(
    input  logic [3:0] op,
    output logic [3:0] fs,
    output logic       mb,
    output logic       md,
    output logic       rw_en,
    output iclass_t    iclass
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        fs     = FS_A;
        mb     = 1'b0;
        md     = 1'b0;
        rw_en  = 1'b0;
        iclass = CL_NOP;
        case (op)
            OP_ADD:  begin fs = FS_ADD; rw_en = 1'b1; iclass = CL_ALU; end
            OP_SUB:  begin fs = FS_SUB; rw_en = 1'b1; iclass = CL_ALU; end
            OP_AND:  begin fs = FS_AND; rw_en = 1'b1; iclass = CL_ALU; end
            OP_OR:   begin fs = FS_OR;  rw_en = 1'b1; iclass = CL_ALU; end
            OP_XOR:  begin fs = FS_XOR; rw_en = 1'b1; iclass = CL_ALU; end
            OP_NOT:  begin fs = FS_NOT; rw_en = 1'b1; iclass = CL_ALU; end
            OP_MOV:  begin fs = FS_B;   rw_en = 1'b1; iclass = CL_ALU; end
            OP_ADI:  begin fs = FS_ADD; mb = 1'b1; rw_en = 1'b1; iclass = CL_IMM; end
            OP_LDI:  begin fs = FS_B;   mb = 1'b1; rw_en = 1'b1; iclass = CL_IMM; end
            // The load's write happens in MEM on the ack cycle, never in EXEC.
            OP_LD:   begin md = 1'b1; rw_en = 1'b1; iclass = CL_LD; end
            OP_ST:   iclass = CL_ST;
            OP_BRZ,
            OP_BRN:  iclass = CL_BRANCH;
            OP_JMP:  iclass = CL_JMP;
            OP_HALT: iclass = CL_HALT;
            default: iclass = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: fetches over imem req/ack, decodes into the
// datapath control word, sequences loads/stores and maintains the PC.
module control_unit
    import cu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [15:0] instr,
    output logic [7:0]  pc,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        V,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    output logic        RW,
    output logic [2:0]  DA,
    output logic [2:0]  AA,
    output logic [2:0]  BA,
    output logic        MB,
    output logic        MD,
    output logic [3:0]  FS,
    output logic [7:0]  const_in,
    output logic        halted
);

    state_t      state;
    logic [15:0] ir;

    logic [3:0]  dec_fs;
    logic        dec_mb;
    logic        dec_md;
    logic        dec_rw_en;
    iclass_t     dec_iclass;

    logic [2:0]  f_dr;
    logic [2:0]  f_sa;
    logic [2:0]  f_sb;
    logic [5:0]  f_imm6;
    logic        branch_taken;

    // Overflow and carry have no consumer in this instruction set.
    logic        unused_flags;
    assign unused_flags = V ^ C;

    assign f_dr   = ir[11:9];
    assign f_sa   = ir[8:6];
    assign f_sb   = ir[5:3];
    assign f_imm6 = ir[5:0];

    cu_decode u_decode (
        .op     (ir[15:12]),
        .fs     (dec_fs),
        .mb     (dec_mb),
        .md     (dec_md),
        .rw_en  (dec_rw_en),
        .iclass (dec_iclass)
    );

    // Flags are combinational from this cycle's control word (FS=A on sa).
    always_comb begin
        branch_taken = 1'b0;
        if (dec_iclass == CL_JMP)
            branch_taken = 1'b1;
        else if (dec_iclass == CL_BRANCH)
            branch_taken = (ir[15:12] == OP_BRZ) ? Z : N;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: IR is a single architectural register, so it is reset with the PC; sequential state uses <= only.
        if (!rst_n) begin
            state <= FETCH;
            pc    <= 8'h00;
            ir    <= 16'h0000;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        ir <= instr;
                        pc <= pc + 8'd1;
                        case (instr[15:12])
                            OP_LD, OP_ST: state <= MEM;
                            OP_HALT:      state <= HALT;
                            default:      state <= EXEC;
                        endcase
                    end
                end
                EXEC: begin
                    // pc already points past the branch, so the offset is relative to pc+1.
                    if (branch_taken)
                        pc <= pc + sext6(f_imm6);
                    state <= FETCH;
                end
                MEM: begin
                    if (dmem_ack)
                        state <= FETCH;
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Control word is a pure decode of registered state/IR, except the load
    // write strobes which must align with the cycle dmem_ack arrives.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        RW       = 1'b0;
        DA       = 3'd0;
        AA       = 3'd0;
        BA       = 3'd0;
        MB       = 1'b0;
        MD       = 1'b0;
        FS       = FS_A;
        const_in = 8'h00;
        halted   = 1'b0;
        case (state)
            FETCH: imem_req = 1'b1;
            EXEC: begin
                FS = dec_fs;
                MB = dec_mb;
                RW = dec_rw_en;
                case (dec_iclass)
                    CL_ALU: begin
                        DA = f_dr;
                        AA = f_sa;
                        BA = f_sb;
                    end
                    CL_IMM: begin
                        DA       = f_dr;
                        AA       = f_sa;
                        const_in = {2'b00, f_imm6};
                    end
                    CL_BRANCH: AA = f_sa;
                    default: ;
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (dec_iclass == CL_ST);
                AA       = f_sa;
                if (dec_iclass == CL_ST)
                    BA = f_sb;
                if (dmem_ack && dec_iclass == CL_LD) begin
                    RW = dec_rw_en;
                    MD = dec_md;
                    DA = f_dr;
                end
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: fetch/exec, waits, loads,
// stores, branches with wrap, halt and asynchronous reset mid-access.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] instr;
    logic [7:0]  pc;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        V, C, N, Z;
    logic        RW;
    logic [2:0]  DA, AA, BA;
    logic        MB, MD;
    logic [3:0]  FS;
    logic [7:0]  const_in;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    control_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .imem_req (imem_req),
        .imem_ack (imem_ack),
        .instr    (instr),
        .pc       (pc),
        .dmem_req (dmem_req),
        .dmem_we  (dmem_we),
        .dmem_ack (dmem_ack),
        .V        (V),
        .C        (C),
        .N        (N),
        .Z        (Z),
        .RW       (RW),
        .DA       (DA),
        .AA       (AA),
        .BA       (BA),
        .MB       (MB),
        .MD       (MD),
        .FS       (FS),
        .const_in (const_in),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One FETCH with `waits` unacked request cycles, then the ack cycle.
    task automatic do_fetch(input logic [15:0] w, input int waits, input logic [7:0] pc_exp);
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            #1;
            check("fetch_wait_req", 16'(imem_req), 16'h1);
            check("fetch_wait_pc", 16'(pc), 16'(pc_exp));
            tick();
        end
        imem_ack = 1'b1;
        instr    = w;
        #1;
        check("fetch_req", 16'(imem_req), 16'h1);
        check("fetch_no_rw", 16'(RW), 16'h0);
        check("fetch_pc", 16'(pc), 16'(pc_exp));
        tick();
        imem_ack = 1'b0;
        instr    = 16'hFFFF;
    endtask

    // One EXEC cycle with the given flags; returns with state back in FETCH.
    task automatic exec_branch(input logic z_in, input logic n_in, input logic [7:0] pc_in_exec);
        Z = z_in;
        N = n_in;
        #1;
        check("exec_pc", 16'(pc), 16'(pc_in_exec));
        check("exec_no_rw", 16'(RW), 16'h0);
        check("exec_no_req", 16'(imem_req), 16'h0);
        tick();
        Z = 1'b0;
        N = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        instr    = 16'h0000;
        dmem_ack = 1'b0;
        {V, C, N, Z} = 4'b0000;

        #12;
        check("rst_imem_req", 16'(imem_req), 16'h1);
        check("rst_pc", 16'(pc), 16'h00);
        check("rst_dmem_req", 16'(dmem_req), 16'h0);
        check("rst_rw", 16'(RW), 16'h0);
        check("rst_halted", 16'(halted), 16'h0);
        check("rst_fs", 16'(FS), 16'h0);
        check("rst_const", 16'(const_in), 16'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ADD r3,r1,r2 zero-wait
        do_fetch(16'h1650, 0, 8'h00);
        #1;
        check("add_pc", 16'(pc), 16'h01);
        check("add_rw", 16'(RW), 16'h1);
        check("add_da", 16'(DA), 16'h3);
        check("add_aa", 16'(AA), 16'h1);
        check("add_ba", 16'(BA), 16'h2);
        check("add_fs", 16'(FS), 16'b0010);
        check("add_mb", 16'(MB), 16'h0);
        check("add_req", 16'(imem_req), 16'h0);
        tick();

        // ADI r1,r1,#63 with three wait cycles
        do_fetch(16'h827F, 3, 8'h01);
        #1;
        check("adi_pc", 16'(pc), 16'h02);
        check("adi_const", 16'(const_in), 16'h3F);
        check("adi_mb", 16'(MB), 16'h1);
        check("adi_fs", 16'(FS), 16'b0010);
        check("adi_rw", 16'(RW), 16'h1);
        check("adi_da", 16'(DA), 16'h1);
        tick();

        // LD r4,[r2] with two data wait cycles
        do_fetch(16'hA880, 0, 8'h02);
        for (int i = 0; i < 2; i++) begin
            dmem_ack = 1'b0;
            #1;
            check("ld_wait_req", 16'(dmem_req), 16'h1);
            check("ld_wait_we", 16'(dmem_we), 16'h0);
            check("ld_wait_rw", 16'(RW), 16'h0);
            check("ld_wait_md", 16'(MD), 16'h0);
            check("ld_wait_aa", 16'(AA), 16'h2);
            check("ld_wait_pc", 16'(pc), 16'h03);
            tick();
        end
        dmem_ack = 1'b1;
        #1;
        check("ld_ack_rw", 16'(RW), 16'h1);
        check("ld_ack_md", 16'(MD), 16'h1);
        check("ld_ack_da", 16'(DA), 16'h4);
        check("ld_ack_aa", 16'(AA), 16'h2);
        check("ld_ack_we", 16'(dmem_we), 16'h0);
        tick();
        dmem_ack = 1'b0;
        #1;
        check("ld_done_dreq", 16'(dmem_req), 16'h0);
        check("ld_done_ireq", 16'(imem_req), 16'h1);

        // ST [r1],r2 zero-wait
        do_fetch(16'hB050, 0, 8'h03);
        dmem_ack = 1'b1;
        #1;
        check("st_dreq", 16'(dmem_req), 16'h1);
        check("st_we", 16'(dmem_we), 16'h1);
        check("st_rw", 16'(RW), 16'h0);
        check("st_aa", 16'(AA), 16'h1);
        check("st_ba", 16'(BA), 16'h2);
        tick();
        dmem_ack = 1'b0;

        // JMP +11 from pc 4 -> 0x10
        do_fetch(16'hE00B, 0, 8'h04);
        exec_branch(1'b0, 1'b0, 8'h05);

        // BRZ r5,#-2 at 0x10, Z=0: fall through to 0x11
        do_fetch(16'hC17E, 0, 8'h10);
        #1;
        check("brz_aa", 16'(AA), 16'h5);
        check("brz_fs", 16'(FS), 16'h0);
        exec_branch(1'b0, 1'b1, 8'h11);

        // JMP -2 from 0x11 -> 0x10
        do_fetch(16'hE03E, 0, 8'h11);
        exec_branch(1'b0, 1'b0, 8'h12);

        // BRZ taken -> 0x0F
        do_fetch(16'hC17E, 0, 8'h10);
        exec_branch(1'b1, 1'b0, 8'h11);

        // BRN at 0x0F with Z=1, N=0: not taken -> 0x10
        do_fetch(16'hD17E, 0, 8'h0F);
        exec_branch(1'b1, 1'b0, 8'h10);

        // BRN at 0x10 with N=1: taken -> 0x0F
        do_fetch(16'hD17E, 0, 8'h10);
        exec_branch(1'b0, 1'b1, 8'h11);

        // JMP -18 from 0x0F -> 0xFE, then JMP +5 at 0xFE wraps to 0x04
        do_fetch(16'hE02E, 0, 8'h0F);
        exec_branch(1'b0, 1'b0, 8'h10);
        do_fetch(16'hE005, 0, 8'hFE);
        exec_branch(1'b0, 1'b0, 8'hFF);

        // NOP at 0x04
        do_fetch(16'h0000, 0, 8'h04);
        #1;
        check("nop_rw", 16'(RW), 16'h0);
        check("nop_sel", 16'({DA, AA, BA}), 16'h0);
        check("nop_fs", 16'(FS), 16'h0);
        check("nop_pc", 16'(pc), 16'h05);
        tick();

        // HALT is absorbing even with imem_ack high
        do_fetch(16'hF000, 0, 8'h05);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            #1;
            check("halt_halted", 16'(halted), 16'h1);
            check("halt_ireq", 16'(imem_req), 16'h0);
            check("halt_rw", 16'(RW), 16'h0);
            check("halt_pc", 16'(pc), 16'h06);
            tick();
        end
        imem_ack = 1'b0;

        rst_n = 1'b0;
        #1;
        check("rst_halt_halted", 16'(halted), 16'h0);
        check("rst_halt_ireq", 16'(imem_req), 16'h1);
        check("rst_halt_pc", 16'(pc), 16'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a load
        do_fetch(16'hA880, 0, 8'h00);
        #1;
        check("mid_mem_dreq", 16'(dmem_req), 16'h1);
        #2;
        dmem_ack = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_pc", 16'(pc), 16'h00);
        check("mid_rst_ireq", 16'(imem_req), 16'h1);
        check("mid_rst_dreq", 16'(dmem_req), 16'h0);
        check("mid_rst_rw", 16'(RW), 16'h0);
        @(negedge clk);
        dmem_ack = 1'b0;
        rst_n    = 1'b1;
        tick();

        // Normal operation resumes from pc 0
        do_fetch(16'h1650, 0, 8'h00);
        #1;
        check("post_rst_pc", 16'(pc), 16'h01);
        check("post_rst_rw", 16'(RW), 16'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
